bcd_display_driver: RTL and testbench
=====================================

// Module: bcd_display_driver
// PURPOSE
//  Generalised calculator result display stage: converts a DATA_W-bit unsigned result to
//  DIGITS decimal digits with a sequential double-dabble converter, then drives one
//  registered active-low 8-bit segment byte per digit {dp,g,f,e,d,c,b,a}.
//  Sits between the ALU result register and the board seven-segment pins.
//  Adds a load/busy/done handshake, a one-deep pending slot and range-overflow detection.
// PARAMETERS
//  DIGITS   3   number of decimal digits driven (1..6)
//  DATA_W   8   input result width in bits (1..20)
// PORTS
//  clock      in   1          system clock, all state on rising edge
//  reset_n    in   1          asynchronous active-low reset
//  load       in   1          1-cycle strobe: capture value and ovf_in
//  value      in   DATA_W     unsigned result to display
//  ovf_in     in   1          ALU overflow flag, sampled with load
//  busy       out  1          conversion in progress
//  done       out  1          1-cycle pulse when the display registers update
//  range_ovf  out  1          latched: last displayed value exceeded 10^DIGITS-1
//  segments   out  8*DIGITS   digit k in [8k+7:8k], k=0 units; active-low, dp always 1
// BEHAVIOUR
//  - Reset: segments all 8'hFF (blank); busy=0, done=0, range_ovf=0; pending slot empty.
//  - Encoding (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 blank=FF dash=BF.
//  - FSM IDLE/CONV/SHOW. IDLE + load: capture value/ovf_in, go to CONV, busy=1 on the next cycle.
//  - CONV: DATA_W iterations, one per cycle: add 3 to every BCD nibble >=5, then shift left
//    by 1 with the next value MSB. The BCD register is DIGITS+1 nibbles wide, so no carry is lost.
//  - SHOW (1 cycle): write segments, pulse done, drop busy, return to IDLE.
//  - Latency: load at edge N -> segments/done valid after edge N+DATA_W+1.
//  - range_ovf=1 when the captured value > 10^DIGITS-1. range_ovf updates only in SHOW.
//  - If range_ovf or the captured ovf_in is set: all digits show dash (BF); the BCD result is discarded.
//  - load while busy: the value is stored in the pending slot; a later load overwrites it (latest wins).
//    In SHOW, a full pending slot starts a new CONV on the next cycle and the slot is emptied.
//  - load in the same cycle as SHOW: treated as pending, not lost.
//  - Value 0: units shows C0. Higher digits follow the CONFIGURATION rule.
//  - A value of all ones at DATA_W is legal and converts normally (e.g. 8'd255 -> 2,5,5).
//  - reset_n low mid-conversion: immediate return to the reset state; the pending slot is cleared.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: zero digits above the most significant non-zero digit
//   show FF. The units digit is never blanked.
//  Not defined: every digit shows its numeral, including leading zeros (e.g. 7 -> C0,C0,F8).
//  Dash display for overflow is unaffected by the macro.
// TESTING (DIGITS=3, DATA_W=8 unless stated)
//  1. Reset: after reset_n low, segments=24'hFFFFFF, busy=0, done=0, range_ovf=0.
//  2. load value=123 -> busy for 8 cycles, done at edge N+9; segments={F9,A4,B0}.
//  3. load 7 -> macro on: {FF,FF,F8}; macro off: {C0,C0,F8}. load 0 -> units=C0.
//  4. DIGITS=2, load 100 -> {BF,BF}, range_ovf=1. Then load 99 -> {90,90}, range_ovf=0.
//     Separately, load 50 with ovf_in=1 -> dashes on all digits.
//  5. load 10, then load 200 and 201 while busy -> 10 shows first, then 201 only
//     ({A4,C0,F9}); two done pulses in total.
//  6. Assert reset_n low at cycle 4 of a conversion -> segments FF immediately;
//     no done pulse follows; the pending slot is empty.

Source files
------------

// File: rtl/bcd_display_driver.sv
// bcd_display_driver
//   Calculator result display stage. A DATA_W-bit unsigned result is converted
//   to DIGITS decimal digits by a sequential double-dabble converter (one bit
//   per cycle). Each digit then drives one registered, active-low segment byte
//   {dp,g,f,e,d,c,b,a}.
//   Handshake: a load strobe starts a conversion. busy is high while the
//   converter iterates. done pulses for one cycle when the display registers
//   update. A one-deep pending slot holds the latest load that arrives while
//   a conversion is in flight.
//   Values that do not fit in DIGITS digits, or that arrive with ovf_in set,
//   show dashes on every digit.
//   Optional feature: define LEADING_ZERO_BLANK_EN to blank zero digits above
//   the most significant non-zero digit. The units digit always stays lit.
module bcd_display_driver #(
    parameter int DIGITS = 3,
    parameter int DATA_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   value,
    input  logic                ovf_in,
    output logic                busy,
    output logic                done,
    output logic                range_ovf,
    output logic [8*DIGITS-1:0] segments
);

    // One spare nibble above the displayed digits keeps every carry in the converter.
    localparam int BCD_W = 4 * (DIGITS + 1);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [31:0] LIMIT    = 32'(pow10(DIGITS) - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    // Active-low segment pattern for one decimal digit.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_SHOW
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    shreg;
    logic [DATA_W-1:0]    cap_val;
    logic                 cap_ovf;
    logic [BCD_W-1:0]     bcd;
    logic                 carry;
    logic                 pend_valid;
    logic [DATA_W-1:0]    pend_val;
    logic                 pend_ovf;

    logic [BCD_W-1:0]     bcd_adj;
    logic [8*DIGITS-1:0]  seg_next;
    logic                 over;
    logic                 dash;
    logic                 start_go;
    logic [DATA_W-1:0]    start_val;
    logic                 start_ovf;

    // Double-dabble correction: add 3 to every nibble that is 5 or more before the shift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        bcd_adj = bcd;
        for (int i = 0; i <= DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Next display contents, built from the finished BCD result and the overflow conditions.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        over     = (32'(cap_val) > LIMIT) || carry;
        dash     = over || cap_ovf;
        seg_next = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (dash) begin
                seg_next[8*k +: 8] = 8'hBF;
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (lead && bcd[4*k +: 4] == 4'd0 && k != 0) begin
                    seg_next[8*k +: 8] = 8'hFF;
                end else begin
                    seg_next[8*k +: 8] = seg_code(bcd[4*k +: 4]);
                    lead               = 1'b0;
                end
`else
                seg_next[8*k +: 8] = seg_code(bcd[4*k +: 4]);
`endif
            end
        end
    end

    // Decide whether a conversion starts this cycle and which operand it uses.
    // A load that arrives during SHOW is newer than the pending slot, so it wins.
    always_comb begin
        start_go  = 1'b0;
        start_val = value;
        start_ovf = ovf_in;
        if (state == S_IDLE && load) begin
            start_go = 1'b1;
        end else if (state == S_SHOW) begin
            if (load) begin
                start_go = 1'b1;
            end else if (pend_valid) begin
                start_go  = 1'b1;
                start_val = pend_val;
                start_ovf = pend_ovf;
            end
        end
    end

    // Control FSM with the converter datapath and the registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            cap_val    <= '0;
            cap_ovf    <= 1'b0;
            bcd        <= '0;
            carry      <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            pend_ovf   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            range_ovf  <= 1'b0;
            segments   <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: ;
                S_CONV: begin
                    if (load) begin
                        pend_valid <= 1'b1;
                        pend_val   <= value;
                        pend_ovf   <= ovf_in;
                    end
                    bcd   <= {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
                    carry <= carry | bcd_adj[BCD_W-1];
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_SHOW;
                        busy  <= 1'b0;
                    end
                end
                S_SHOW: begin
                    segments   <= seg_next;
                    range_ovf  <= over;
                    done       <= 1'b1;
                    pend_valid <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (start_go) begin
                state   <= S_CONV;
                busy    <= 1'b1;
                cnt     <= '0;
                shreg   <= start_val;
                cap_val <= start_val;
                cap_ovf <= start_ovf;
                bcd     <= '0;
                carry   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver
//   Drives two instances with identical stimulus: a 3-digit one and a 2-digit
//   one, both with 8-bit data. A transaction-level model predicts busy, done,
//   range_ovf and segments for every cycle. It computes digits by plain
//   division and models the pipeline as a countdown per job.
//   Directed sequences pin the model with literal expectations. Randomized
//   loads, overflow flags and occasional resets follow.
module tb_bcd_display_driver;

    localparam int DW = 8;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        load    = 1'b0;
    logic [7:0]  value   = '0;
    logic        ovf_in  = 1'b0;

    logic        busy3, done3, rovf3;
    logic [23:0] seg3;
    logic        busy2, done2, rovf2;
    logic [15:0] seg2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bcd_display_driver #(.DIGITS(3), .DATA_W(8)) dut3 (
        .clock(clock), .reset_n(reset_n), .load(load), .value(value), .ovf_in(ovf_in),
        .busy(busy3), .done(done3), .range_ovf(rovf3), .segments(seg3)
    );

    bcd_display_driver #(.DIGITS(2), .DATA_W(8)) dut2 (
        .clock(clock), .reset_n(reset_n), .load(load), .value(value), .ovf_in(ovf_in),
        .busy(busy2), .done(done2), .range_ovf(rovf2), .segments(seg2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] enc(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int lim_of(input int nd);
        int p;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [23:0] model_seg(input int v, input bit o, input int nd);
        logic [23:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            if (o || v >= lim_of(nd)) r[8*k +: 8] = 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
            else if (k > 0 && v < p) r[8*k +: 8] = 8'hFF;
`endif
            else r[8*k +: 8] = enc((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [23:0] blank_of(input int nd);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < nd; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    // Per instance: timer counts edges left until the display update (0 = no job).
    int          m_nd    [2] = '{3, 2};
    int          m_timer [2];
    int          m_val   [2];
    bit          m_ovf   [2];
    bit          m_pv    [2];
    int          m_pval  [2];
    bit          m_povf  [2];
    logic [23:0] m_seg   [2];
    bit          m_done  [2];
    bit          m_range [2];

    always @(posedge clock or negedge reset_n) begin
        bit st;
        int sv;
        bit so;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_timer[i] = 0;
                m_pv[i]    = 0;
                m_seg[i]   = blank_of(m_nd[i]);
                m_done[i]  = 0;
                m_range[i] = 0;
            end else begin
                st = 0;
                sv = int'(value);
                so = ovf_in;
                m_done[i] = 0;
                if (m_timer[i] > 0) begin
                    m_timer[i]--;
                    if (m_timer[i] == 0) begin
                        m_seg[i]   = model_seg(m_val[i], m_ovf[i], m_nd[i]);
                        m_range[i] = (m_val[i] >= lim_of(m_nd[i]));
                        m_done[i]  = 1;
                        if (load) st = 1;
                        else if (m_pv[i]) begin
                            st = 1; sv = m_pval[i]; so = m_povf[i];
                        end
                        m_pv[i] = 0;
                    end else if (load) begin
                        m_pv[i] = 1; m_pval[i] = int'(value); m_povf[i] = ovf_in;
                    end
                end else if (load) begin
                    st = 1;
                end
                if (st) begin
                    m_val[i]   = sv;
                    m_ovf[i]   = so;
                    m_timer[i] = DW + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("busy3",  32'(busy3), 32'(m_timer[0] >= 2));
        check("done3",  32'(done3), 32'(m_done[0]));
        check("range3", 32'(rovf3), 32'(m_range[0]));
        check("seg3",   32'(seg3),  32'(m_seg[0]));
        check("busy2",  32'(busy2), 32'(m_timer[1] >= 2));
        check("done2",  32'(done2), 32'(m_done[1]));
        check("range2", 32'(rovf2), 32'(m_range[1]));
        check("seg2",   32'(seg2),  32'(m_seg[1][15:0]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input int v, input bit o);
        @(negedge clock);
        load   = 1'b1;
        value  = 8'(v);
        ovf_in = o;
        @(negedge clock);
        load   = 1'b0;
        ovf_in = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (busy3) busy_cnt++;
        end while (!done3 && cyc < budget);
        if (!done3) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout after %0d cycles", cyc);
        end
    endtask

    initial begin
        int cyc, bc, nd, b0;
        logic [23:0] first_seg;

        // 1. reset state
        repeat (3) @(negedge clock);
        check("rst_seg3",  32'(seg3),  32'h00FFFFFF);
        check("rst_seg2",  32'(seg2),  32'h0000FFFF);
        check("rst_busy",  32'(busy3), 32'h0);
        check("rst_done",  32'(done3), 32'h0);
        check("rst_range", 32'(rovf3), 32'h0);
        #2 reset_n = 1'b1;

        // 2. value 123: busy for 8 cycles, done at edge N+9
        do_load(123, 0);
        b0 = int'(busy3);
        wait_done(40, cyc, bc);
        check("lat_123",  32'(cyc), 32'd9);
        check("busy_123", 32'(bc + b0), 32'd8);
        check("seg_123",  32'(seg3), 32'h00F9A4B0);

        // 3. leading zeros
        do_load(7, 0);
        wait_done(40, cyc, bc);
`ifdef LEADING_ZERO_BLANK_EN
        check("seg_7", 32'(seg3), 32'h00FFFFF8);
`else
        check("seg_7", 32'(seg3), 32'h00C0C0F8);
`endif
        do_load(0, 0);
        wait_done(40, cyc, bc);
        check("units_0", 32'(seg3[7:0]), 32'hC0);

        // 4. range overflow on the 2-digit instance, and ALU overflow dashes
        do_load(100, 0);
        wait_done(40, cyc, bc);
        check("seg2_100",   32'(seg2),  32'h0000BFBF);
        check("range2_100", 32'(rovf2), 32'h1);
        check("seg3_100",   32'(seg3),  32'h00F9C0C0);
        do_load(99, 0);
        wait_done(40, cyc, bc);
        check("seg2_99",   32'(seg2),  32'h00009090);
        check("range2_99", 32'(rovf2), 32'h0);
        do_load(50, 1);
        wait_done(40, cyc, bc);
        check("seg3_ovf",   32'(seg3),  32'h00BFBFBF);
        check("seg2_ovf",   32'(seg2),  32'h0000BFBF);
        check("range3_ovf", 32'(rovf3), 32'h0);

        // 5. pending slot: latest load wins
        do_load(10, 0);
        do_load(200, 0);
        do_load(201, 0);
        nd = 0;
        first_seg = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done3) begin
                nd++;
                if (nd == 1) first_seg = seg3;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("pend_first", 32'(first_seg), 32'h00FFF9C0);
`else
        check("pend_first", 32'(first_seg), 32'h00C0F9C0);
`endif
        check("pend_last",  32'(seg3), 32'h00A4C0F9);
        check("pend_dones", 32'(nd),   32'd2);

        // 6. reset mid-conversion, with a pending load queued
        do_load(45, 0);
        do_load(77, 0);
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_seg",  32'(seg3),  32'h00FFFFFF);
        check("mid_rst_busy", 32'(busy3), 32'h0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done3) nd++;
        end
        check("mid_rst_nodone", 32'(nd), 32'd0);

        // Randomized traffic: boundary-biased values, occasional ALU overflow and resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            load = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 7))
                0:       value = 8'd0;
                1:       value = 8'd255;
                2:       value = 8'(99 + $urandom_range(0, 1));
                3:       value = 8'(999 % 256);
                default: value = 8'($urandom_range(0, 255));
            endcase
            ovf_in = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clock);
        load   = 1'b0;
        ovf_in = 1'b0;
        repeat (30) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
